apb_regbank: RTL and testbench

Parametrised APB slave register bank generalising the rotate engine's fixed-map register interface. It has a configurable register count and wait-state insertion, and supports per-register read-only, self-clearing and write-one-to-clear attributes. It reports PSLVERR and raises a level interrupt from W1C status bits. It sits between the APB interconnect and the rotate core/DMA, exporting all registers flat to the core.

---
 rtl/apb_regbank.sv | 257 +++++++++++++++++++++++++
 tb/tb_apb_regbank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
//==============================================================================
// Module      : apb_regbank
// Description : Parametrised APB slave register bank. NUM_REGS 32-bit
//               registers at byte offsets 4*n, optional access-phase wait
//               states, per-register read-only / self-clearing /
//               write-one-to-clear attributes, PSLVERR reporting and a level
//               interrupt built from the W1C status bits. All register
//               contents are exported flat to the core.
// Options     : define APB_PSTRB_EN to honour I_PSTRB byte strobes; when it
//               is undefined all four bytes are always written.
// Ports       : I_PCLK, I_PRESET_N         clock, async active-low reset
//               I_PSEL/I_PENABLE/I_PWRITE  APB controls
//               I_PADDR, I_PWDATA, I_PSTRB APB address / write data / strobes
//               O_PRDATA, O_PREADY,        registered APB responses
//               O_PSLVERR
//               O_REGS                     flat register contents
//               I_RO_DATA                  core values for RO registers
//               I_HW_SET                   set pulses for W1C registers
//               O_INTERRUPT                registered OR of all W1C bits
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_regbank #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [63:0] RO_MASK     = 64'h0,
  parameter logic [63:0] SC_MASK     = 64'h0,
  parameter logic [63:0] W1C_MASK    = 64'h0
) (
  input  logic                     I_PCLK,
  input  logic                     I_PRESET_N,
  input  logic                     I_PSEL,
  input  logic                     I_PENABLE,
  input  logic                     I_PWRITE,
  input  logic [31:0]              I_PADDR,
  input  logic [31:0]              I_PWDATA,
  input  logic [3:0]               I_PSTRB,
  output logic [31:0]              O_PRDATA,
  output logic                     O_PREADY,
  output logic                     O_PSLVERR,
  output logic [32*NUM_REGS-1:0]   O_REGS,
  input  logic [32*NUM_REGS-1:0]   I_RO_DATA,
  input  logic [32*NUM_REGS-1:0]   I_HW_SET,
  output logic                     O_INTERRUPT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // Address decode and error detection
  // ---------------------------------------------------------------------------
  logic [13:0] idx;
  logic        hit;
  logic        hit_ro;
  logic [31:0] hit_rdata;
  logic        err;
  logic [31:0] rd_val [NUM_REGS];
  logic [NUM_REGS-1:0] w1c_bits;

  assign idx = I_PADDR[15:2];

  always_comb begin
    hit       = 1'b0;
    hit_ro    = 1'b0;
    hit_rdata = 32'h0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (idx == 14'(n)) begin
        hit       = 1'b1;
        hit_ro    = RO_MASK[n];
        hit_rdata = rd_val[n];
      end
    end
  end

  assign err = !hit || (I_PADDR[1:0] != 2'b00) || (I_PWRITE && hit_ro);

  // ---------------------------------------------------------------------------
  // Byte-lane write mask
  // ---------------------------------------------------------------------------
  logic [31:0] byte_mask;
  logic [31:0] wr_data;

`ifdef APB_PSTRB_EN
  assign byte_mask = {{8{I_PSTRB[3]}}, {8{I_PSTRB[2]}},
                      {8{I_PSTRB[1]}}, {8{I_PSTRB[0]}}};
`else
  assign byte_mask = 32'hFFFF_FFFF;
`endif

  assign wr_data = I_PWDATA & byte_mask;

  // Upper address bits, strobes (when disabled) and the input slices of
  // registers without the matching attribute are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{I_PADDR[31:16], I_PSTRB, I_RO_DATA, I_HW_SET};

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        slverr_q, slverr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        enter_done;
  logic        commit_wr;

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    slverr_d   = 1'b0;
    rdata_d    = rdata_q;
    enter_done = 1'b0;
    commit_wr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_PSEL && !I_PENABLE) begin
          cnt_d = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!I_PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        if (!I_PSEL) begin
          state_d = ST_IDLE;
        end else if (I_PENABLE) begin
          // The error flag was captured on entry to DONE against the same
          // (stable) address, so it gates the commit directly.
          commit_wr = I_PWRITE && !slverr_q;
          state_d   = ST_IDLE;
        end else begin
          ready_d  = 1'b1;
          slverr_d = slverr_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_done) begin
      state_d  = ST_DONE;
      ready_d  = 1'b1;
      slverr_d = err;
      if (!I_PWRITE) begin
        rdata_d = err ? 32'h0 : hit_rdata;
      end
    end
  end

  assign O_PREADY  = ready_q;
  assign O_PSLVERR = slverr_q;
  assign O_PRDATA  = rdata_q;

  // ---------------------------------------------------------------------------
  // Register storage, one generate slice per register
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    logic [31:0] q;
    logic        sel_wr;

    assign sel_wr = commit_wr && (idx == 14'(n));

    if (RO_MASK[n]) begin : g_ro
      // Storage is never written; reads come from the core.
      assign q = 32'h0;
    end else if (W1C_MASK[n]) begin : g_w1c
      // Hardware set is OR-ed in after the clear so set wins.
      always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
          q <= 32'h0;
        end else begin
          q <= (q & ~(sel_wr ? wr_data : 32'h0)) | I_HW_SET[32*n +: 32];
        end
      end
    end else if (SC_MASK[n]) begin : g_sc
      // Holds the written value for exactly one cycle.
      always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
          q <= 32'h0;
        end else begin
          q <= sel_wr ? wr_data : 32'h0;
        end
      end
    end else begin : g_rw
      always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
          q <= 32'h0;
        end else if (sel_wr) begin
          q <= (q & ~byte_mask) | wr_data;
        end
      end
    end

    assign O_REGS[32*n +: 32] = q;
    assign rd_val[n]          = RO_MASK[n] ? I_RO_DATA[32*n +: 32] : q;
    assign w1c_bits[n]        = W1C_MASK[n] ? (|q) : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Interrupt: registered OR of all W1C status bits
  // ---------------------------------------------------------------------------
  logic irq_q;

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |w1c_bits;
    end
  end

  assign O_INTERRUPT = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_regbank.sv
//==============================================================================
// Module      : tb_apb_regbank
// Description : Self-checking bench for apb_regbank. Three instances share
//               one APB bus with separate PSEL lines: a plain RW bank, a bank
//               with RO/W1C/SC attributes, and a bank with three wait states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_regbank;

  localparam int NR = 16;
  localparam int VW = 32 * NR;

`ifdef APB_PSTRB_EN
  localparam logic [31:0] EXP_STRB = 32'h0000_CC00;
`else
  localparam logic [31:0] EXP_STRB = 32'hAABB_CCDD;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel_rw = 1'b0, psel_at = 1'b0, psel_wt = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [31:0]   paddr = 32'h0;
  logic [31:0]   pwdata = 32'h0;
  logic [3:0]    pstrb = 4'h0;
  logic [VW-1:0] zero_v = '0;
  logic [VW-1:0] ro_at = '0;
  logic [VW-1:0] hw_at = '0;

  logic [31:0]   rd_rw, rd_at, rd_wt;
  logic          rdy_rw, rdy_at, rdy_wt;
  logic          err_rw, err_at, err_wt;
  logic          irq_rw, irq_at, irq_wt;
  logic [VW-1:0] regs_rw, regs_at, regs_wt;

  always #5 clk = ~clk;

  apb_regbank #(.NUM_REGS(NR), .WAIT_STATES(0)) u_rw (
    .I_PCLK(clk), .I_PRESET_N(rst_n), .I_PSEL(psel_rw), .I_PENABLE(penable),
    .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
    .O_PRDATA(rd_rw), .O_PREADY(rdy_rw), .O_PSLVERR(err_rw), .O_REGS(regs_rw),
    .I_RO_DATA(zero_v), .I_HW_SET(zero_v), .O_INTERRUPT(irq_rw));

  apb_regbank #(.NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(64'h4),
                .SC_MASK(64'h100), .W1C_MASK(64'h8)) u_at (
    .I_PCLK(clk), .I_PRESET_N(rst_n), .I_PSEL(psel_at), .I_PENABLE(penable),
    .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
    .O_PRDATA(rd_at), .O_PREADY(rdy_at), .O_PSLVERR(err_at), .O_REGS(regs_at),
    .I_RO_DATA(ro_at), .I_HW_SET(hw_at), .O_INTERRUPT(irq_at));

  apb_regbank #(.NUM_REGS(NR), .WAIT_STATES(3)) u_wt (
    .I_PCLK(clk), .I_PRESET_N(rst_n), .I_PSEL(psel_wt), .I_PENABLE(penable),
    .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
    .O_PRDATA(rd_wt), .O_PREADY(rdy_wt), .O_PSLVERR(err_wt), .O_REGS(regs_wt),
    .I_RO_DATA(zero_v), .I_HW_SET(zero_v), .O_INTERRUPT(irq_wt));

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic dut_ready(input int d);
    case (d)
      0:       return rdy_rw;
      1:       return rdy_at;
      default: return rdy_wt;
    endcase
  endfunction

  function automatic logic dut_err(input int d);
    case (d)
      0:       return err_rw;
      1:       return err_at;
      default: return err_wt;
    endcase
  endfunction

  function automatic logic [31:0] dut_rdata(input int d);
    case (d)
      0:       return rd_rw;
      1:       return rd_at;
      default: return rd_wt;
    endcase
  endfunction

  function automatic logic [31:0] dut_reg(input int d, input int n);
    case (d)
      0:       return regs_rw[32*n +: 32];
      1:       return regs_at[32*n +: 32];
      default: return regs_wt[32*n +: 32];
    endcase
  endfunction

  task automatic set_psel(input int d, input logic v);
    psel_rw = (d == 0) ? v : 1'b0;
    psel_at = (d == 1) ? v : 1'b0;
    psel_wt = (d == 2) ? v : 1'b0;
  endtask

  // One APB transfer; returns read data, error and the number of access
  // cycles spent waiting before PREADY. Returns with the bus idle, 1 time
  // unit after the commit edge.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic slverr,
                          output int waits);
    @(posedge clk); #1;
    set_psel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    while (!dut_ready(d) && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!dut_ready(d)) begin
      n_chk++;
      n_bad++;
      $display("FAIL pready_timeout: got 0 required 1 (addr 0x%08h)", addr);
    end
    rdata  = dut_rdata(d);
    slverr = dut_err(d);
    @(posedge clk); #1;
    set_psel(d, 1'b0);
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
    int          reg_chk;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    logic        seen;

    //        dut wr  addr           wdata          strb   exp_rd         err wt  reg exp_reg
    vecs[0]  = '{0, 1, 32'h0000_0008, 32'hDEADBEEF, 4'hF, 32'h0,         0, 0, 2,  32'hDEADBEEF};
    vecs[1]  = '{0, 0, 32'h0000_0008, 32'h0,        4'hF, 32'hDEADBEEF,  0, 0, 2,  32'hDEADBEEF};
    vecs[2]  = '{0, 1, 32'h0000_0040, 32'h11111111, 4'hF, 32'h0,         1, 0, 2,  32'hDEADBEEF};
    vecs[3]  = '{0, 1, 32'h0000_0005, 32'h22222222, 4'hF, 32'h0,         1, 0, 1,  32'h0};
    vecs[4]  = '{0, 0, 32'h0000_0040, 32'h0,        4'hF, 32'h0,         1, 0, -1, 32'h0};
    vecs[5]  = '{0, 1, 32'h0000_0004, 32'hAABBCCDD, 4'h2, 32'h0,         0, 0, 1,  EXP_STRB};
    vecs[6]  = '{0, 0, 32'h0000_0004, 32'h0,        4'hF, EXP_STRB,      0, 0, 1,  EXP_STRB};
    vecs[7]  = '{0, 1, 32'h0000_003C, 32'h5A5A5A5A, 4'hF, 32'h0,         0, 0, 15, 32'h5A5A5A5A};
    vecs[8]  = '{0, 0, 32'h0000_003C, 32'h0,        4'hF, 32'h5A5A5A5A,  0, 0, 15, 32'h5A5A5A5A};
    vecs[9]  = '{0, 1, 32'h0001_0010, 32'hCAFEF00D, 4'hF, 32'h0,         0, 0, 4,  32'hCAFEF00D};
    vecs[10] = '{1, 0, 32'h0000_0008, 32'h0,        4'hF, 32'h12345678,  0, 0, -1, 32'h0};
    vecs[11] = '{1, 1, 32'h0000_0008, 32'hFFFFFFFF, 4'hF, 32'h0,         1, 0, -1, 32'h0};
    vecs[12] = '{1, 0, 32'h0000_0008, 32'h0,        4'hF, 32'h12345678,  0, 0, -1, 32'h0};
    vecs[13] = '{2, 0, 32'h0000_0000, 32'h0,        4'hF, 32'h0,         0, 3, -1, 32'h0};
    vecs[14] = '{2, 1, 32'h0000_003C, 32'h00001234, 4'hF, 32'h0,         0, 3, 15, 32'h00001234};
    vecs[15] = '{2, 0, 32'h0000_003C, 32'h0,        4'hF, 32'h00001234,  0, 3, 15, 32'h00001234};

    ro_at[95:64] = 32'h12345678;

    // Reset state, sampled while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {29'h0, rdy_rw, rdy_at, rdy_wt}, 32'h0);
    check("rst_pslverr", {29'h0, err_rw, err_at, err_wt}, 32'h0);
    check("rst_prdata", rd_rw | rd_at | rd_wt, 32'h0);
    check("rst_regs", {29'h0, |regs_rw, |regs_at, |regs_wt}, 32'h0);
    check("rst_irq", {29'h0, irq_rw, irq_at, irq_wt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < 16; i++) begin
      apb_xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].strb, rd, er, w);
      check($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
      if (!vecs[i].wr)
        check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].reg_chk >= 0)
        check($sformatf("v%0d_oregs", i), dut_reg(vecs[i].dut, vecs[i].reg_chk),
              vecs[i].exp_reg);
    end

    // Abort a wait-state write by dropping PSEL in WAIT
    @(posedge clk); #1;
    set_psel(2, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0000FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    set_psel(2, 1'b0);
    penable = 1'b0; pwrite = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | rdy_wt;
    end
    check("abort_no_pready", {31'h0, seen}, 32'h0);
    check("abort_no_write", dut_reg(2, 0), 32'h0);
    apb_xfer(2, 1'b0, 32'h0000_003C, 32'h0, 4'hF, rd, er, w);
    check("post_abort_waits", 32'(w), 32'd3);
    check("post_abort_prdata", rd, 32'h00001234);

    // W1C: hardware set, then clear racing a set, then a real clear
    check("w1c_irq_idle", {31'h0, irq_at}, 32'h0);
    @(posedge clk); #1;
    hw_at[96] = 1'b1;
    @(posedge clk); #1;
    hw_at[96] = 1'b0;
    check("w1c_set_reg", dut_reg(1, 3), 32'h1);
    check("w1c_irq_lag", {31'h0, irq_at}, 32'h0);
    @(posedge clk); #1;
    check("w1c_irq_set", {31'h0, irq_at}, 32'h1);
    hw_at[96] = 1'b1;
    apb_xfer(1, 1'b1, 32'h0000_000C, 32'h1, 4'hF, rd, er, w);
    hw_at[96] = 1'b0;
    check("w1c_set_wins", dut_reg(1, 3), 32'h1);
    apb_xfer(1, 1'b1, 32'h0000_000C, 32'h1, 4'hF, rd, er, w);
    check("w1c_cleared", dut_reg(1, 3), 32'h0);
    check("w1c_irq_hold", {31'h0, irq_at}, 32'h1);
    @(posedge clk); #1;
    check("w1c_irq_fall", {31'h0, irq_at}, 32'h0);

    // Self-clearing register: one-cycle pulse on O_REGS
    apb_xfer(1, 1'b1, 32'h0000_0020, 32'h1, 4'hF, rd, er, w);
    check("sc_pulse_hi", {31'h0, regs_at[256]}, 32'h1);
    @(posedge clk); #1;
    check("sc_pulse_lo", {31'h0, regs_at[256]}, 32'h0);

    // Asynchronous reset in the middle of an access phase
    @(posedge clk); #1;
    set_psel(0, 1'b1);
    penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0008;
    @(posedge clk); #1;
    penable = 1'b1;
    check("arst_pre_pready", {31'h0, rdy_rw}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pready", {31'h0, rdy_rw}, 32'h0);
    check("arst_regs", dut_reg(0, 2), 32'h0);
    check("arst_prdata", rd_rw, 32'h0);
    set_psel(0, 1'b0);
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
